camera_config_sequencer: RTL and testbench
==========================================

CAMERA_CONFIG_SEQUENCER -- requirements
Module: camera_config_sequencer

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 24'd10_000_000: length of the FFF0 delay, in clk cycles.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to run the configuration table from entry 0.
REQ-005 SHALL have port rom_addr  output  8  table address driven to the configuration ROM.
REQ-006 SHALL have port rom_data  input  16  ROM word {reg[15:8], val[7:0]}; valid one clk after rom_addr changes.
REQ-007 SHALL have port sccb_start  output  1  write request to the SCCB master.
REQ-008 SHALL have port sccb_reg  output  8  sensor register address for the current write.
REQ-009 SHALL have port sccb_val  output  8  sensor register value for the current write.
REQ-010 SHALL have port sccb_ready  input  1  SCCB master idle and able to accept a write.
REQ-011 SHALL have port busy  output  1  sequence in progress.
REQ-012 SHALL have port done  output  1  table completed; sticky.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, SEND, DELAY and DONE.
REQ-014 IDLE: rom_addr=0 and busy=0; start=1 moves to FETCH and sets busy=1.
REQ-015 FETCH: holds rom_addr for one cycle to cover the ROM latency, then moves to DECODE.
REQ-016 DECODE, rom_data=16'hFFFF: moves to DONE.
REQ-017 DECODE, rom_data=16'hFFF0: loads the delay counter with DELAY_CYCLES-1 and moves to DELAY.
REQ-018 DECODE, any other rom_data: latches sccb_reg=rom_data[15:8] and sccb_val=rom_data[7:0], then moves to SEND.
REQ-019 SEND: sccb_start=1, with sccb_reg and sccb_val held stable until accepted.
REQ-020 SEND: a write is accepted in the cycle where sccb_start=1 and sccb_ready=1.
REQ-021 On acceptance, the next cycle SHALL have sccb_start=0 and rom_addr+1, and the state SHALL go to FETCH.
REQ-022 SEND: sccb_ready=0 holds SEND with no timeout.
REQ-023 sccb_start SHALL never be high outside SEND, and exactly one accepted write SHALL occur per non-marker entry.
REQ-024 DELAY: decrements the counter every cycle; at counter=0 it increments rom_addr and moves to FETCH.
REQ-025 DELAY: the delay lasts exactly DELAY_CYCLES cycles, with sccb_start=0 throughout.
REQ-026 Address 255: a non-marker entry at 255 is written, then the state goes to DONE. rom_addr SHALL NOT wrap to 0.
REQ-027 DONE: busy=0 and done=1; start=1 clears done, sets rom_addr=0 and moves to FETCH.
REQ-028 start SHALL be ignored in FETCH, DECODE, SEND and DELAY.
REQ-029 Latency: start sampled at edge N gives FETCH after N, DECODE after N+1, and sccb_start=1 after N+2 for a register entry.
REQ-030 The delay counter SHALL be 24 bits wide.
REQ-031 DELAY_CYCLES=1 SHALL give a one-cycle DELAY; DELAY_CYCLES=0 SHALL be treated as 1.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, rom_addr=0, sccb_start=0, sccb_reg=0, sccb_val=0, busy=0, done=0 and counter=0.
REQ-033 Reset asserted in any state, including mid-SEND and mid-DELAY, SHALL abort the sequence with no further sccb_start.
REQ-034 After reset release, the block SHALL wait in IDLE for start.

Verification (bench ROM model with 1-cycle latency; DELAY_CYCLES=4)
REQ-035 Table {1280, FFF0, 1204, FFFF}, sccb_ready=1, start pulse -> writes (12,80) then (12,04). Gap of exactly 4 DELAY cycles. done=1 with rom_addr=3.
REQ-036 Table {1100, FFFF}, sccb_ready=0 for 10 cycles after SEND entry -> sccb_start held 10 cycles with reg=11, val=00 stable. Exactly one write on ready=1.
REQ-037 Table with no FFFF in addresses 0..255 -> 256 writes, then DONE. rom_addr stays 255 and no second pass occurs.
REQ-038 rst_n pulsed low mid-DELAY, then start -> outputs at reset values during reset. Sequence restarts at entry 0 and no write is skipped or duplicated.
REQ-039 start held high throughout a run -> ignored while busy. From DONE, start=1 reruns the table and done drops the cycle after.
REQ-040 Table {FFFF} -> DONE reached 2 cycles after start, with zero sccb_start pulses.

Source files
------------

// File: rtl/camera_config_sequencer.sv
// Camera configuration sequencer: walks a {reg, val} ROM table from entry 0 and issues one SCCB
// write per entry. 16'hFFF0 inserts a DELAY_CYCLES pause and 16'hFFFF ends the table.
module camera_config_sequencer #(
  parameter logic [23:0] DELAY_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  input  logic        sccb_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] EndMarker   = 16'hFFFF;
  localparam logic [15:0] DelayMarker = 16'hFFF0;
  localparam logic [7:0]  LastAddr    = 8'hFF;
  // A zero-length delay would underflow the counter, so it runs as a one-cycle delay.
  localparam logic [23:0] DelayLoad   = (DELAY_CYCLES == 24'd0) ? 24'd0
                                                                : DELAY_CYCLES - 24'd1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StSend,
    StDelay,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  val_q, val_d;

  // Entry 255 is the last one: the table finishes there instead of wrapping to 0.
  logic        at_last;
  state_e      next_entry_state;
  logic [7:0]  next_entry_addr;

  assign at_last          = (addr_q == LastAddr);
  assign next_entry_state = at_last ? StDone : StFetch;
  assign next_entry_addr  = at_last ? addr_q : addr_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= 8'd0;
      cnt_q   <= 24'd0;
      reg_q   <= 8'd0;
      val_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    val_d   = val_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end

      // rom_data lags rom_addr by one cycle; this state only waits it out.
      StFetch: begin
        state_d = StDecode;
      end

      StDecode: begin
        if (rom_data == EndMarker) begin
          state_d = StDone;
        end else if (rom_data == DelayMarker) begin
          cnt_d   = DelayLoad;
          state_d = StDelay;
        end else begin
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
          state_d = StSend;
        end
      end

      // No timeout: a stalled SCCB master holds the request indefinitely.
      StSend: begin
        if (sccb_ready) begin
          addr_d  = next_entry_addr;
          state_d = next_entry_state;
        end
      end

      StDelay: begin
        if (cnt_q == 24'd0) begin
          addr_d  = next_entry_addr;
          state_d = next_entry_state;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end

      StDone: begin
        if (start) begin
          addr_d  = 8'd0;
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rom_addr   = addr_q;
  assign sccb_start = (state_q == StSend);
  assign sccb_reg   = reg_q;
  assign sccb_val   = val_q;
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer: a table-walking model predicts every write, its
// cycle gap and each end-of-table event; directed tests pin the model with literals.
module tb_camera_config_sequencer;

  localparam int Dly = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_start;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_val;
  logic        sccb_ready;
  logic        busy;
  logic        done;

  logic [15:0] rom [256];

  int checks = 0;
  int errors = 0;

  camera_config_sequencer #(
    .DELAY_CYCLES(24'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sccb_start(sccb_start),
    .sccb_reg  (sccb_reg),
    .sccb_val  (sccb_val),
    .sccb_ready(sccb_ready),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  // ROM with one clock of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: expected writes and end-of-pass events. Gaps are in cycles from the last
  // anchor (start accepted from idle/done, or a write accepted) to the event.
  typedef struct {
    logic [7:0] addr;
    logic [7:0] r;
    logic [7:0] v;
    int         gap;
  } wr_t;

  typedef struct {
    logic [7:0] addr;
    int         gap;
    int         nwr;
  } pass_t;

  wr_t   exp_q[$];
  pass_t pass_q[$];
  int    gap_log[$];
  int    wr_count = 0;
  logic [15:0] last_wr = 16'h0;
  bit    mon_en = 1'b0;

  task automatic build_expect();
    int    gap = 3;
    int    n = 0;
    wr_t   w;
    pass_t p;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        p.addr = 8'(a);
        p.gap  = gap;
        p.nwr  = n;
        pass_q.push_back(p);
        return;
      end else if (rom[a] == 16'hFFF0) begin
        gap += Dly + 2;
      end else begin
        w.addr = 8'(a);
        w.r    = rom[a][15:8];
        w.v    = rom[a][7:0];
        w.gap  = gap;
        exp_q.push_back(w);
        n++;
        gap = 3;
      end
    end
    // Ran off the end of the table: finishes without the fetch/decode of a marker.
    p.addr = 8'hFF;
    p.gap  = gap - 2;
    p.nwr  = n;
    pass_q.push_back(p);
  endtask

  // Compare process
  initial begin
    int since = 0;
    int pass_wr = 0;
    bit prev_start = 1'b0;
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        since = 0;
        prev_start = 1'b0;
        prev_done = 1'b0;
      end else begin
        since++;
        chk("start_while_not_busy", int'(sccb_start & ~busy), 0);
        chk("busy_and_done", int'(busy & done), 0);
        if (sccb_start && !prev_start) begin
          gap_log.push_back(since);
          if (exp_q.size() == 0) chk("write_expected", exp_q.size(), 1);
          else chk("write_gap", since, exp_q[0].gap);
        end
        if (sccb_start && exp_q.size() > 0) begin
          chk("write_addr", int'(rom_addr), int'(exp_q[0].addr));
          chk("write_reg", int'(sccb_reg), int'(exp_q[0].r));
          chk("write_val", int'(sccb_val), int'(exp_q[0].v));
        end
        if (sccb_start && sccb_ready) begin
          if (exp_q.size() > 0) exp_q.delete(0);
          wr_count++;
          pass_wr++;
          last_wr = {sccb_reg, sccb_val};
          since = 0;
        end
        if (done && !prev_done) begin
          if (pass_q.size() == 0) begin
            chk("done_expected", pass_q.size(), 1);
          end else begin
            chk("done_gap", since, pass_q[0].gap);
            chk("done_addr", int'(rom_addr), int'(pass_q[0].addr));
            chk("pass_writes", pass_wr, pass_q[0].nwr);
            pass_q.delete(0);
          end
        end
        if (start && !busy) begin
          since = 0;
          pass_wr = 0;
        end
        prev_start = sccb_start;
        prev_done = done;
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic go();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_reached"}, int'(done), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rom_addr"}, int'(rom_addr), 0);
    chk({name, "_sccb_start"}, int'(sccb_start), 0);
    chk({name, "_sccb_reg"}, int'(sccb_reg), 0);
    chk({name, "_sccb_val"}, int'(sccb_val), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int starts;
    rst_n = 1'b0;
    start = 1'b0;
    sccb_ready = 1'b1;
    clear_rom();
    #2;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_addr", int'(rom_addr), 0);

    // Register writes around a delay marker
    clear_rom();
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
    rom[3] = 16'hFFFF;
    build_expect();
    chk("model_t1_writes", exp_q.size(), 2);
    chk("model_t1_gap", exp_q[1].gap, 9);
    chk("model_t1_addr", int'(pass_q[0].addr), 3);
    gap_log.delete();
    wr_count = 0;
    go();
    wait_done("t1", 100);
    chk("t1_writes", wr_count, 2);
    chk("t1_first_gap", (gap_log.size() > 0) ? gap_log[0] : -1, 3);
    chk("t1_delay_gap", (gap_log.size() > 1) ? gap_log[1] : -1, 9);
    chk("t1_last_write", int'(last_wr), 32'h1204);
    chk("t1_addr", int'(rom_addr), 3);
    chk("t1_busy", int'(busy), 0);

    // SCCB master stalls for 10 cycles
    @(posedge clk); #1;
    clear_rom();
    rom[0] = 16'h1100;
    build_expect();
    wr_count = 0;
    sccb_ready = 1'b0;
    go();
    n = 0;
    while (!sccb_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_send_entered", int'(sccb_start), 1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold", int'({sccb_start, sccb_reg, sccb_val}), int'({1'b1, 8'h11, 8'h00}));
      @(posedge clk); #1;
      if (i == 9) sccb_ready = 1'b1;
      @(negedge clk);
    end
    wait_done("t2", 50);
    chk("t2_writes", wr_count, 1);

    // No end marker anywhere: 256 writes, no wrap
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      rom[i] = {b ^ 8'h5A, b};
    end
    build_expect();
    chk("model_t3_writes", exp_q.size(), 256);
    chk("model_t3_done_gap", pass_q[0].gap, 1);
    wr_count = 0;
    go();
    wait_done("t3", 2000);
    chk("t3_writes", wr_count, 256);
    chk("t3_addr", int'(rom_addr), 255);
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (sccb_start || busy) starts++;
    end
    chk("t3_no_second_pass", starts, 0);
    chk("t3_addr_held", int'(rom_addr), 255);
    chk("t3_done_held", int'(done), 1);

    // Reset in the middle of a delay, then rerun
    @(posedge clk); #1;
    clear_rom();
    rom[0] = 16'h2233;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h4455;
    build_expect();
    wr_count = 0;
    go();
    n = 0;
    while (rom_addr != 8'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_first_write_done", int'(rom_addr), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    pass_q.delete();
    #1;
    check_reset_outputs("t4_rst");
    repeat (3) begin
      @(negedge clk);
      chk("t4_rst_no_start", int'(sccb_start), 0);
      chk("t4_rst_busy", int'(busy), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_idle_busy", int'(busy), 0);
    chk("t4_idle_addr", int'(rom_addr), 0);
    build_expect();
    wr_count = 0;
    go();
    wait_done("t4", 100);
    chk("t4_writes", wr_count, 2);
    chk("t4_addr", int'(rom_addr), 3);

    // start held high across a whole run, then a rerun from done
    @(posedge clk); #1;
    clear_rom();
    rom[0] = 16'h3344;
    build_expect();
    build_expect();
    wr_count = 0;
    start = 1'b1;
    @(posedge clk); #1;
    wait_done("t5a", 50);
    @(negedge clk);
    chk("t5_done_drops", int'(done), 0);
    chk("t5_busy_again", int'(busy), 1);
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5b", 50);
    chk("t5_writes", wr_count, 2);

    // Empty table straight after reset
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    pass_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_rom();
    build_expect();
    chk("model_t6_writes", exp_q.size(), 0);
    chk("model_t6_done_gap", pass_q[0].gap, 3);
    wr_count = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_fetch_busy", int'(busy), 1);
    chk("t6_fetch_done", int'(done), 0);
    @(posedge clk); #1;
    chk("t6_decode_done", int'(done), 0);
    @(posedge clk); #1;
    chk("t6_done", int'(done), 1);
    chk("t6_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_writes", wr_count, 0);

    chk("final_writes_pending", exp_q.size(), 0);
    chk("final_passes_pending", pass_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
